// File: rtl/ysyx_24080006_lsu_pkg.sv
// Shared definitions for the load/store unit: RV funct3 width codes,
// write-back select encodings and the LSU control state type.
package ysyx_24080006_pkg;

  localparam int DATA_W = 32;

  // Load width/sign codes
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store width codes (share encodings with the signed loads)
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Write-back source select, {mem,alu}
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_MEM = 2'b10;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/ysyx_24080006_lsu_align.sv
// Combinational byte-lane logic: builds lane-replicated store data and
// byte enables, extracts and extends load data, and flags accesses that
// are misaligned or use a funct3 code that is illegal for the operation.
module ysyx_24080006_lsu_align
  import ysyx_24080006_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        addr_lo,
  input  logic              is_store,
  input  logic [DATA_W-1:0] rs2,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] wdata,
  output logic [3:0]        wmask,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misaligned
);

  // Byte extension; sgn selects sign- versus zero-extension.
  function automatic logic signed [DATA_W-1:0] ext_byte(input logic [7:0] b,
                                                         input logic       sgn);
    logic signed [8:0] t;
    t = signed'({sgn & b[7], b});
    return DATA_W'(t);
  endfunction

  // Halfword extension; sgn selects sign- versus zero-extension.
  function automatic logic signed [DATA_W-1:0] ext_half(input logic [15:0] h,
                                                         input logic        sgn);
    logic signed [16:0] t;
    t = signed'({sgn & h[15], h});
    return DATA_W'(t);
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

  // Decode width code into lane data, byte enables, load value and legality.
  always_comb begin
    wdata      = '0;
    wmask      = '0;
    rdata_ext  = '0;
    misaligned = 1'b0;
    case (funct3)
      F3_LB: begin
        wdata     = {4{rs2[7:0]}};
        wmask     = 4'b0001 << addr_lo;
        rdata_ext = ext_byte(byte_sel, 1'b1);
      end
      F3_LH: begin
        misaligned = addr_lo[0];
        wdata      = {2{rs2[15:0]}};
        wmask      = 4'b0011 << {addr_lo[1], 1'b0};
        rdata_ext  = ext_half(half_sel, 1'b1);
      end
      F3_LW: begin
        misaligned = (addr_lo != 2'b00);
        wdata      = rs2;
        wmask      = 4'b1111;
        rdata_ext  = rdata;
      end
      F3_LBU: begin
        // Unsigned widths exist only for loads.
        misaligned = is_store;
        rdata_ext  = ext_byte(byte_sel, 1'b0);
      end
      F3_LHU: begin
        misaligned = is_store | addr_lo[0];
        rdata_ext  = ext_half(half_sel, 1'b0);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ysyx_24080006_lsu.sv
// Multi-cycle load/store unit between EXU and WBU. Accepts one instruction
// at a time, issues at most one word-aligned bus request, waits for the
// response (with optional timeout), and presents the result to WBU.
module ysyx_24080006_lsu
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        exu_valid,
  output logic        exu_ready,
  input  logic [31:0] alu_result,
  input  logic [31:0] rs2_data,
  input  logic [2:0]  funct3,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [1:0]  wb_sel_i,
  input  logic [4:0]  rd_i,
  output logic        wbu_valid,
  input  logic        wbu_ready,
  output logic [31:0] alu_result_o,
  output logic [31:0] mem_rdata,
  output logic [1:0]  wb_sel_o,
  output logic [4:0]  rd_o,
  output logic        lsu_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata
);

  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TIMEOUT_LIM = 32'(TIMEOUT_CYCLES);

  lsu_state_t  state;
  logic [31:0] resp_cnt;
  logic [2:0]  funct3_p0;

  logic        in_idle;
  logic [2:0]  al_funct3;
  logic [1:0]  al_addr_lo;
  logic        al_is_store;
  logic [31:0] al_wdata;
  logic [3:0]  al_wmask;
  logic [31:0] al_rdata_ext;
  logic        al_misaligned;

  // While idle the lane logic looks at the incoming instruction; afterwards
  // it looks at the captured one so the response can be extracted.
  assign in_idle     = (state == LSU_IDLE);
  assign al_funct3   = in_idle ? funct3 : funct3_p0;
  assign al_addr_lo  = in_idle ? alu_result[1:0] : alu_result_o[1:0];
  assign al_is_store = in_idle ? mem_wen : mem_req_wen;

  ysyx_24080006_lsu_align u_align (
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .is_store   (al_is_store),
    .rs2        (rs2_data),
    .rdata      (mem_resp_rdata),
    .wdata      (al_wdata),
    .wmask      (al_wmask),
    .rdata_ext  (al_rdata_ext),
    .misaligned (al_misaligned)
  );

  // Control FSM with registered handshake, bus and result outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= LSU_IDLE;
      exu_ready     <= 1'b0;
      wbu_valid     <= 1'b0;
      lsu_err       <= 1'b0;
      mem_req_valid <= 1'b0;
      mem_req_wen   <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      alu_result_o  <= '0;
      mem_rdata     <= '0;
      wb_sel_o      <= '0;
      rd_o          <= '0;
      funct3_p0     <= '0;
      resp_cnt      <= '0;
    end else begin
      case (state)
        // Capture stage: latch the instruction and decide the path.
        LSU_IDLE: begin
          exu_ready <= 1'b1;
          if (exu_valid && exu_ready) begin
            exu_ready    <= 1'b0;
            alu_result_o <= alu_result;
            wb_sel_o     <= wb_sel_i;
            rd_o         <= rd_i;
            funct3_p0    <= funct3;
            mem_rdata    <= '0;
            lsu_err      <= 1'b0;
            resp_cnt     <= '0;
            if (!(mem_ren || mem_wen)) begin
              state     <= LSU_DONE;
              wbu_valid <= 1'b1;
            end else if (al_misaligned) begin
              state     <= LSU_DONE;
              wbu_valid <= 1'b1;
              lsu_err   <= 1'b1;
            end else begin
              state         <= LSU_REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {alu_result[31:2], 2'b00};
              mem_req_wen   <= mem_wen;
              mem_req_wdata <= mem_wen ? al_wdata : '0;
              mem_req_wmask <= mem_wen ? al_wmask : 4'b0000;
            end
          end
        end
        // Request stage: hold the request until the bus takes it.
        LSU_REQ: begin
          if (mem_req_ready) begin
            state         <= LSU_RESP;
            mem_req_valid <= 1'b0;
            resp_cnt      <= '0;
          end
        end
        // Response stage: a response wins over a timeout in the same cycle.
        LSU_RESP: begin
          resp_cnt <= resp_cnt + 32'd1;
          if (mem_resp_valid) begin
            state     <= LSU_DONE;
            wbu_valid <= 1'b1;
            mem_rdata <= mem_req_wen ? 32'd0 : al_rdata_ext;
          end else if (TIMEOUT_EN && ((resp_cnt + 32'd1) == TIMEOUT_LIM)) begin
            state     <= LSU_DONE;
            wbu_valid <= 1'b1;
            lsu_err   <= 1'b1;
            mem_rdata <= '0;
          end
        end
        // Result stage: hold everything until WBU takes it.
        LSU_DONE: begin
          if (wbu_ready) begin
            state     <= LSU_IDLE;
            wbu_valid <= 1'b0;
            exu_ready <= 1'b1;
          end
        end
        default: begin
          state <= LSU_IDLE;
        end
      endcase
    end
  end

endmodule
